sd_spi_arbiter: RTL and testbench
=================================

Name: sd_spi_arbiter

Overview:
- Shares the single SD-card SPI bus (spi_cs/spi_clk/spi_mosi/spi_miso pads) between two SPI masters, e.g. the CPU SPI port and a future hardware boot/DMA loader.
- Level-sensitive request/grant with round-robin fairness, a CS-high guard interval between owners, and an optional watchdog that reclaims a stalled bus.
- Sits between VirtualToplevel-side masters and the board pins in the toplevel, clocked by sysclk.

Parameters:
- GUARD_CYCLES, 8, clk cycles the bus is held idle (CS high) after an owner releases, before the next grant; legal range 1..255.
- TIMEOUT_W, 16, width of the inactivity watchdog counter.
- TIMEOUT_CYCLES, 65535, cycles without owner bus activity before a forced release; must be below 2^TIMEOUT_W.

Ports:
- clk  in  1  system clock (sysclk).
- reset_in  in  1  asynchronous, active-low reset.
- req0, req1  in  1 each  bus request from master 0/1 (level).
- gnt0, gnt1  out  1 each  grant to master 0/1 (registered).
- m0_cs, m1_cs  in  1 each  master chip select (active-low).
- m0_clk, m1_clk  in  1 each  master SPI clock.
- m0_mosi, m1_mosi  in  1 each  master data out.
- m0_miso, m1_miso  out  1 each  data returned to master 0/1.
- spi_cs  out  1  pad chip select (active-low).
- spi_clk  out  1  pad SPI clock.
- spi_mosi  out  1  pad MOSI.
- spi_miso  in  1  pad MISO.
- busy  out  1  high in OWN0, OWN1 and GUARD.
- owner  out  1  index of the current or most recent owner.
- timeout_evt  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async, immediate, including mid-transfer): gnt0=gnt1=0, spi_cs=1, spi_clk=0, spi_mosi=1, busy=0, owner=0, timeout_evt=0, state=IDLE, last_owner=1 so master 0 wins the first tie, lockout0=lockout1=0.
- States:
  - IDLE: all pad outputs at idle levels.
  - OWN0 / OWN1: granted master drives the bus.
  - GUARD: bus idle, counting.
- IDLE transitions:
  - Single eligible request goes straight to the matching OWNx.
  - Both eligible: grant the master that is not last_owner.
  - A request is eligible when reqX=1 and lockoutX=0.
  - gntX rises on the clock edge that enters OWNx, one cycle after req is sampled; owner and last_owner update on that same edge.
- OWNx: holds while reqX=1. When reqX is sampled low, go to GUARD; gntX falls on that edge.
- GUARD:
  - Load the counter with GUARD_CYCLES-1 on entry, decrement each cycle, enter IDLE at 0.
  - Requests are ignored during GUARD.
  - Minimum gap between a grant falling and the next grant rising is GUARD_CYCLES+1 cycles.
- Pad outputs:
  - Registered: spi_cs/spi_clk/spi_mosi = registered copy of the owner's m_cs/m_clk/m_mosi, one cycle latency.
  - Forced to idle levels (1/0/1) in IDLE and GUARD and in the first OWN cycle.
- MISO routing (combinational): m0_miso = gnt0 ? spi_miso : 1. m1_miso likewise.
- Non-owner master inputs are ignored entirely.
- The same req dropping and re-rising within one cycle counts as a release.

Optional Feature:
- Macro SPI_ARB_TIMEOUT_EN.
- When defined:
  - In OWNx, a TIMEOUT_W-bit counter clears on entry and whenever the owner's m_clk or m_cs differs from its previous-cycle value; otherwise it increments.
  - On reaching TIMEOUT_CYCLES: go to GUARD, drop gntX, pulse timeout_evt for one cycle, set lockoutX=1.
  - lockoutX clears when reqX is sampled low.
- When not defined: no counter or lockout logic; timeout_evt is tied 0; an owner may hold the bus indefinitely.

Test Plan:
- Reset release, req0=1 at cycle 5 -> gnt0=1 at cycle 6; owner=0, busy=1; spi_cs follows m0_cs one cycle later; m1_miso=1 throughout.
- req0 and req1 rise together from reset -> gnt0 first. After req0 drops, gnt1 rises exactly GUARD_CYCLES+1=9 cycles after gnt0 falls. A later simultaneous pair is granted to master 0 again (alternation).
- Master 1 owns, spi_miso toggled 0/1 -> m1_miso mirrors it the same cycle; m0_miso=1. Master 0 toggles m0_clk -> spi_clk stays 0.
- reset_in pulsed low mid-transfer with m0_cs=0 -> spi_cs=1, gnt0=0 and busy=0 immediately, without waiting for a clock edge.
- SPI_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, master 0 holds req0 with static m0_clk/m0_cs:
  - gnt0 drops after 100 idle cycles and timeout_evt pulses for 1 cycle.
  - req0 held high is not re-granted; req0 low then high -> granted again.
- Macro undefined, same stimulus -> gnt0 stays high for 10000 cycles; timeout_evt=0.

Source files
------------

// File: rtl/sd_spi_arbiter.sv
// Round-robin arbiter sharing one SD-card SPI bus between two masters, with a CS-high guard gap.
// Define SPI_ARB_TIMEOUT_EN to add an inactivity watchdog that reclaims a stalled bus.
module sd_spi_arbiter #(
    parameter int GUARD_CYCLES   = 8,
    parameter int TIMEOUT_W      = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic reset_in,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    input  logic m0_cs,
    input  logic m1_cs,
    input  logic m0_clk,
    input  logic m1_clk,
    input  logic m0_mosi,
    input  logic m1_mosi,
    output logic m0_miso,
    output logic m1_miso,
    output logic spi_cs,
    output logic spi_clk,
    output logic spi_mosi,
    input  logic spi_miso,
    output logic busy,
    output logic owner,
    output logic timeout_evt
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, GUARD} state_e;

    state_e     state_q, state_d;
    logic [7:0] guard_q, guard_d;
    logic       gnt0_q, gnt1_q;
    logic       owner_q, owner_d, last_owner_q, last_owner_d;
    logic       spi_cs_q, spi_clk_q, spi_mosi_q;
    logic       spi_cs_d, spi_clk_d, spi_mosi_d;
    logic       in_own, own_req, own_cs, own_clk, own_mosi;
    logic       release_own, tmo_fire, elig0, elig1;

    assign in_own      = (state_q == OWN0) || (state_q == OWN1);
    assign own_req     = (state_q == OWN1) ? req1    : req0;
    assign own_cs      = (state_q == OWN1) ? m1_cs   : m0_cs;
    assign own_clk     = (state_q == OWN1) ? m1_clk  : m0_clk;
    assign own_mosi    = (state_q == OWN1) ? m1_mosi : m0_mosi;
    assign release_own = in_own && !own_req;

`ifdef SPI_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic                 m0_cs_q, m0_clk_q, m1_cs_q, m1_clk_q;
    logic                 lock0_q, lock1_q, lock0_d, lock1_d;
    logic                 own_active, timeout_evt_q;

    assign own_active = (state_q == OWN1) ? ((m1_cs != m1_cs_q) || (m1_clk != m1_clk_q))
                                          : ((m0_cs != m0_cs_q) || (m0_clk != m0_clk_q));
    assign tmo_fire   = in_own && own_req && !own_active
                        && (tmo_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    assign tmo_d      = (in_own && !own_active) ? tmo_q + TIMEOUT_W'(1) : '0;
    // A lockout survives until its master lets go of req, so a stuck master cannot re-grab the bus.
    assign lock0_d    = (tmo_fire && (state_q == OWN0)) || (lock0_q && req0);
    assign lock1_d    = (tmo_fire && (state_q == OWN1)) || (lock1_q && req1);
    assign elig0      = req0 && !lock0_q;
    assign elig1      = req1 && !lock1_q;
    assign timeout_evt = timeout_evt_q;

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            tmo_q         <= '0;
            m0_cs_q       <= 1'b1;
            m0_clk_q      <= 1'b0;
            m1_cs_q       <= 1'b1;
            m1_clk_q      <= 1'b0;
            lock0_q       <= 1'b0;
            lock1_q       <= 1'b0;
            timeout_evt_q <= 1'b0;
        end else begin
            tmo_q         <= tmo_d;
            m0_cs_q       <= m0_cs;
            m0_clk_q      <= m0_clk;
            m1_cs_q       <= m1_cs;
            m1_clk_q      <= m1_clk;
            lock0_q       <= lock0_d;
            lock1_q       <= lock1_d;
            timeout_evt_q <= tmo_fire;
        end
    end
`else
    assign tmo_fire    = 1'b0;
    assign elig0       = req0;
    assign elig1       = req1;
    assign timeout_evt = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        guard_d      = guard_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (elig0 && (!elig1 || last_owner_q)) begin
                    state_d      = OWN0;
                    owner_d      = 1'b0;
                    last_owner_d = 1'b0;
                end else if (elig1) begin
                    state_d      = OWN1;
                    owner_d      = 1'b1;
                    last_owner_d = 1'b1;
                end
            end
            OWN0, OWN1: begin
                if (release_own || tmo_fire) begin
                    state_d = GUARD;
                    guard_d = 8'(GUARD_CYCLES - 1);
                end
            end
            GUARD: begin
                if (guard_q == 8'd0) state_d = IDLE;
                else                 guard_d = guard_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pads only carry owner data while ownership continues across the edge; the first
    // owned cycle and the cycle after a release both present idle levels.
    always_comb begin
        spi_cs_d   = 1'b1;
        spi_clk_d  = 1'b0;
        spi_mosi_d = 1'b1;
        if (in_own && (state_d == state_q)) begin
            spi_cs_d   = own_cs;
            spi_clk_d  = own_clk;
            spi_mosi_d = own_mosi;
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q      <= IDLE;
            guard_q      <= 8'd0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            spi_cs_q     <= 1'b1;
            spi_clk_q    <= 1'b0;
            spi_mosi_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            guard_q      <= guard_d;
            gnt0_q       <= (state_d == OWN0);
            gnt1_q       <= (state_d == OWN1);
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            spi_cs_q     <= spi_cs_d;
            spi_clk_q    <= spi_clk_d;
            spi_mosi_q   <= spi_mosi_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign owner    = owner_q;
    assign busy     = (state_q != IDLE);
    assign spi_cs   = spi_cs_q;
    assign spi_clk  = spi_clk_q;
    assign spi_mosi = spi_mosi_q;
    assign m0_miso  = gnt0_q ? spi_miso : 1'b1;
    assign m1_miso  = gnt1_q ? spi_miso : 1'b1;

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Bench for sd_spi_arbiter: a cycle model of owner/guard/lockout rules checked every cycle,
// plus directed scenarios with literal expectations. Define SPI_ARB_TIMEOUT_EN to cover the watchdog.
module tb_sd_spi_arbiter;

    localparam int G = 8;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int T = 100;
`else
    localparam int T = 65535;
`endif

    logic clk = 1'b0;
    logic reset_in = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0;
    logic m0_cs = 1'b1, m1_cs = 1'b1, m0_clk = 1'b0, m1_clk = 1'b0;
    logic m0_mosi = 1'b1, m1_mosi = 1'b1, spi_miso = 1'b1;
    logic gnt0, gnt1, m0_miso, m1_miso, spi_cs, spi_clk, spi_mosi, busy, owner, timeout_evt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sd_spi_arbiter #(
        .GUARD_CYCLES  (G),
        .TIMEOUT_W     (16),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk        (clk),
        .reset_in   (reset_in),
        .req0       (req0),
        .req1       (req1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .m0_cs      (m0_cs),
        .m1_cs      (m1_cs),
        .m0_clk     (m0_clk),
        .m1_clk     (m1_clk),
        .m0_mosi    (m0_mosi),
        .m1_mosi    (m1_mosi),
        .m0_miso    (m0_miso),
        .m1_miso    (m1_miso),
        .spi_cs     (spi_cs),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .busy       (busy),
        .owner      (owner),
        .timeout_evt(timeout_evt)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the bus (-1 = nobody), earliest edge a new grant may happen,
    // quiet-cycle count of the owner, and per-master lockouts.
    int   e_own, e_last, e_owner, e_cyc, e_grant_ok, e_quiet;
    bit   e_lock[2], lk_old[2];
    logic e_evt, e_cs, e_clk, e_mosi;
    logic rq[2], mc[2], mk[2], mm[2], p_cs[2], p_clk[2];
    bit   act, rel, el0, el1;

    always @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            e_own = -1; e_last = 1; e_owner = 0; e_cyc = 0; e_grant_ok = 0; e_quiet = 0;
            e_lock[0] = 0; e_lock[1] = 0;
            e_evt = 0; e_cs = 1; e_clk = 0; e_mosi = 1;
            p_cs[0] = 1; p_cs[1] = 1; p_clk[0] = 0; p_clk[1] = 0;
        end else begin
            rq[0] = req0;   rq[1] = req1;
            mc[0] = m0_cs;  mc[1] = m1_cs;
            mk[0] = m0_clk; mk[1] = m1_clk;
            mm[0] = m0_mosi; mm[1] = m1_mosi;
            e_cyc++;
            e_evt = 0;
            lk_old = e_lock;
            for (int i = 0; i < 2; i++) if (!rq[i]) e_lock[i] = 0;
            e_cs = 1; e_clk = 0; e_mosi = 1;
            if (e_own >= 0) begin
                act = (mk[e_own] != p_clk[e_own]) || (mc[e_own] != p_cs[e_own]);
                e_quiet = act ? 0 : e_quiet + 1;
                rel = !rq[e_own];
`ifdef SPI_ARB_TIMEOUT_EN
                if (!rel && e_quiet >= T) begin
                    rel = 1; e_evt = 1; e_lock[e_own] = 1;
                end
`endif
                if (rel) begin
                    e_own = -1;
                    e_grant_ok = e_cyc + G + 1;
                end else begin
                    e_cs = mc[e_own]; e_clk = mk[e_own]; e_mosi = mm[e_own];
                end
            end else if (e_cyc >= e_grant_ok) begin
                el0 = rq[0] && !lk_old[0];
                el1 = rq[1] && !lk_old[1];
                if (el0 && el1) e_own = (e_last == 0) ? 1 : 0;
                else if (el0)   e_own = 0;
                else if (el1)   e_own = 1;
                if (e_own >= 0) begin
                    e_last = e_own; e_owner = e_own; e_quiet = 0;
                end
            end
            p_cs = mc; p_clk = mk;
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset_in) begin
            chk("gnt0", gnt0, e_own == 0);
            chk("gnt1", gnt1, e_own == 1);
            chk("busy", busy, (e_own >= 0) || (e_cyc < e_grant_ok - 1));
            chk("owner", owner, e_owner[0]);
            chk("timeout_evt", timeout_evt, e_evt);
            chk("spi_cs", spi_cs, e_cs);
            chk("spi_clk", spi_clk, e_clk);
            chk("spi_mosi", spi_mosi, e_mosi);
            chk("m0_miso", m0_miso, (e_own == 0) ? spi_miso : 1'b1);
            chk("m1_miso", m1_miso, (e_own == 1) ? spi_miso : 1'b1);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_in = 0;
        req0 = 0; req1 = 0; m0_cs = 1; m1_cs = 1; m0_clk = 0; m1_clk = 0;
        m0_mosi = 1; m1_mosi = 1; spi_miso = 1;
        repeat (2) @(negedge clk);
        reset_in = 1;
    endtask

    int n, bad;

    initial begin
        // Reset state and first grant
        do_reset();
        #1;
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_gnt1", gnt1, 1'b0);
        chk("rst_spi_cs", spi_cs, 1'b1);
        chk("rst_spi_clk", spi_clk, 1'b0);
        chk("rst_spi_mosi", spi_mosi, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 1'b0);
        chk("rst_evt", timeout_evt, 1'b0);
        repeat (4) @(negedge clk);
        req0 = 1;
        @(posedge clk); #1;
        chk("t1_gnt0", gnt0, 1'b1);
        chk("t1_busy", busy, 1'b1);
        chk("t1_owner", owner, 1'b0);
        chk("t1_first_cs", spi_cs, 1'b1);
        @(negedge clk);
        m0_cs = 0;
        @(posedge clk); #1;
        chk("t1_cs_follow", spi_cs, 1'b0);
        chk("t1_m1_miso", m1_miso, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            m0_clk = ~m0_clk; m0_mosi = i[1]; spi_miso = i[0];
            m1_cs = i[0]; m1_clk = i[1]; m1_mosi = i[2];
        end
        @(negedge clk);
        m0_cs = 1; m0_clk = 0; req0 = 0; m1_cs = 1; m1_clk = 0;

        // Simultaneous requests from reset, guard gap, MISO routing, alternation
        do_reset();
        req0 = 1; req1 = 1;
        @(posedge clk); #1;
        chk("t2_first_gnt0", gnt0, 1'b1);
        chk("t2_first_gnt1", gnt1, 1'b0);
        repeat (4) @(negedge clk);
        req0 = 0;
        @(posedge clk); #1;
        chk("t2_gnt0_fall", gnt0, 1'b0);
        n = 0;
        while (!gnt1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk_int("t2_grant_gap", n, G + 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            spi_miso = i[0]; m0_clk = ~m0_clk;
            #1;
            chk("t2_m1_miso", m1_miso, i[0]);
            chk("t2_m0_miso", m0_miso, 1'b1);
            @(posedge clk); #1;
            chk("t2_spi_clk_isolated", spi_clk, 1'b0);
        end
        @(negedge clk);
        req1 = 0; m0_clk = 0;
        repeat (G + 3) @(negedge clk);
        req0 = 1; req1 = 1;
        @(posedge clk); #1;
        chk("t2_alt_gnt0", gnt0, 1'b1);
        chk("t2_alt_gnt1", gnt1, 1'b0);
        @(negedge clk);
        req1 = 0;

        // Asynchronous reset in the middle of a transfer
        m0_cs = 0; m0_clk = 1;
        repeat (2) @(negedge clk);
        @(posedge clk); #3;
        reset_in = 0;
        #1;
        chk("t3_async_cs", spi_cs, 1'b1);
        chk("t3_async_gnt0", gnt0, 1'b0);
        chk("t3_async_busy", busy, 1'b0);
        @(negedge clk);
        req0 = 0; req1 = 0; m0_cs = 1; m0_clk = 0;
        reset_in = 1;
        repeat (2) @(negedge clk);

`ifdef SPI_ARB_TIMEOUT_EN
        // Watchdog: static owner is reclaimed, then locked out until req drops
        req0 = 1;
        n = 0;
        while (!gnt0 && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t4_grant", gnt0, 1'b1);
        n = 0;
        while (gnt0 && n < T + 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk_int("t4_hold_cycles", n, T);
        chk("t4_evt_pulse", timeout_evt, 1'b1);
        @(posedge clk); #1;
        chk("t4_evt_one_cycle", timeout_evt, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        chk("t4_locked_out", gnt0, 1'b0);
        @(negedge clk);
        req0 = 0;
        @(negedge clk);
        req0 = 1;
        n = 0;
        while (!gnt0 && n < G + 5) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t4_regrant", gnt0, 1'b1);
        @(negedge clk);
        req0 = 0;
`else
        // No watchdog: a static owner keeps the bus
        req0 = 1;
        n = 0;
        while (!gnt0 && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t4_grant", gnt0, 1'b1);
        bad = 0;
        repeat (10000) begin
            @(posedge clk); #1;
            if (!gnt0 || timeout_evt) bad++;
        end
        chk_int("t4_hold_10000", bad, 0);
        @(negedge clk);
        req0 = 0;
`endif
        repeat (G + 4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
